// File: rtl/myproject_dense_accum_22s_16s_if.sv
// Stream bundle for the dense-layer accumulator: product/bias input side and
// rounded/saturated result output side, each with valid/ready handshakes.
interface myproject_dense_accum_22s_16s_if #(
  parameter int PROD_WIDTH = 22,
  parameter int ACC_WIDTH  = 28,
  parameter int OUT_WIDTH  = 16
);
  logic signed [PROD_WIDTH-1:0] prod_data;
  logic                         prod_valid;
  logic                         prod_ready;
  logic signed [ACC_WIDTH-1:0]  bias;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_sat;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output prod_data, prod_valid, bias, out_ready,
    input  prod_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  prod_data, prod_valid, bias, out_ready,
    output prod_ready, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/myproject_dense_accum_22s_16s.sv
// Dense-layer accumulator: sums N_IN signed products plus a per-neuron bias,
// then rounds half-up, drops SHIFT fraction bits and saturates to OUT_WIDTH.
module myproject_dense_accum_22s_16s #(
  parameter int PROD_WIDTH = 22,
  parameter int ACC_WIDTH  = 28,
  parameter int N_IN       = 16,
  parameter int SHIFT      = 4,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  myproject_dense_accum_22s_16s_if.slave  bus
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);
  localparam logic signed [ACC_WIDTH:0] MAX_R = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] MIN_R = ~MAX_R;

  typedef enum logic {
    ACCUM,
    OUTPUT
  } state_e;

  state_e                       state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [OUT_WIDTH-1:0]  out_data_q;
  logic                         out_sat_q;
  logic                         out_valid_q;

  logic                         accept;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  base;
  logic signed [ACC_WIDTH-1:0]  sum_d;
  logic signed [ACC_WIDTH:0]    sum_x;
  logic signed [ACC_WIDTH:0]    r_d;
  logic signed [OUT_WIDTH-1:0]  out_data_d;
  logic                         out_sat_d;

  assign bus.prod_ready = (state_q == ACCUM);
  assign bus.out_data   = out_data_q;
  assign bus.out_sat    = out_sat_q;
  assign bus.out_valid  = out_valid_q;

  // The first product of a frame restarts from the bias instead of the old sum.
  always_comb begin
    accept   = bus.prod_valid && (state_q == ACCUM);
    prod_ext = {{(ACC_WIDTH-PROD_WIDTH){bus.prod_data[PROD_WIDTH-1]}}, bus.prod_data};
    base     = (cnt_q == '0) ? bus.bias : acc_q;
    sum_d    = base + prod_ext;
    sum_x    = {sum_d[ACC_WIDTH-1], sum_d};
  end

  if (SHIFT == 0) begin : g_noshift
    assign r_d = sum_x;
  end else begin : g_round
    localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) <<< (SHIFT - 1);
    logic signed [ACC_WIDTH:0] biased;
    assign biased = sum_x + HALF;
    assign r_d    = biased >>> SHIFT;
  end

  always_comb begin
    out_data_d = r_d[OUT_WIDTH-1:0];
    out_sat_d  = 1'b0;
    if (r_d > MAX_R) begin
      out_data_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      out_sat_d  = 1'b1;
    end else if (r_d < MIN_R) begin
      out_data_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      out_sat_d  = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q <= sum_d;
            if (cnt_q == LAST) begin
              cnt_q       <= '0;
              out_data_q  <= out_data_d;
              out_sat_q   <= out_sat_d;
              out_valid_q <= 1'b1;
              state_q     <= OUTPUT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/myproject_dense_accum_22s_16s.md
Name: myproject_dense_accum_22s_16s

Overview:
Accumulation stage directly downstream of the 16s x 6s -> 22-bit signed product multipliers in the dense layer datapath. It consumes a stream of N_IN signed products per output neuron and adds a per-neuron bias. It then rounds, shifts and saturates the sum to the layer's 16-bit fixed-point output. Valid/ready handshakes are used on both sides, so the block can sit between the multiplier array and the activation stage.

Parameters:
PROD_WIDTH, 22, signed product input width (matches multiplier dout)
ACC_WIDTH, 28, internal accumulator width; must be >= PROD_WIDTH + clog2(N_IN) + 1 (guaranteed no overflow)
N_IN, 16, products per output frame (>= 1)
SHIFT, 4, fractional bits dropped at output (>= 0)
OUT_WIDTH, 16, signed output width

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst_n  in  1  asynchronous active-low reset
prod_data  in  PROD_WIDTH  signed product from multiplier
prod_valid  in  1  prod_data valid
prod_ready  out  1  block accepts prod_data this cycle
bias  in  ACC_WIDTH  signed bias, already aligned to product LSB; sampled with first product of frame
out_data  out  OUT_WIDTH  signed rounded/saturated result
out_sat  out  1  result was clipped (qualified by out_valid)
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data

Behaviour:
- Reset (async assert, sync deassert externally): state=ACCUM, cnt=0, acc=0, out_data=0, out_sat=0, out_valid=0. Reset mid-frame discards partial sum; no output for that frame.
- States: ACCUM, OUTPUT.
- prod_ready = (state==ACCUM). It is combinational from state only, with no dependency on prod_valid.
- Accept = prod_valid && prod_ready.
- ACCUM, accept with cnt==0: acc <= sext(bias) + sext(prod_data).
- ACCUM, accept with cnt>0: acc <= acc + sext(prod_data).
- cnt increments per accept.
- ACCUM, accept with cnt==N_IN-1: the final sum is computed combinationally. out_data/out_sat are registered from it, out_valid <= 1, cnt <= 0, state <= OUTPUT.
- Latency: out_valid rises on the edge that accepts the last product, i.e. it is visible the cycle after the last accept.
- No accept in a cycle: acc and cnt hold. Gaps of any length between products are legal.
- OUTPUT: out_data, out_sat and out_valid hold stable until out_valid && out_ready. On that edge, out_valid <= 0 and state <= ACCUM.
- prod_ready is therefore 0 for at least one cycle per frame; the next frame's first product can be accepted the cycle after the handshake.
- Rounding is round-half-up in two's complement: r = (sum + 2^(SHIFT-1)) >>> SHIFT. If SHIFT==0, r = sum. The add is done in ACC_WIDTH+1 bits.
- Saturation: if r > 2^(OUT_WIDTH-1)-1, output max with out_sat=1; if r < -2^(OUT_WIDTH-1), output min with out_sat=1; otherwise output r[OUT_WIDTH-1:0] with out_sat=0.
- N_IN==1: every accept produces an output, and bias is added to that single product.
- No combinational path from out_ready to prod_ready or from prod_valid to out_valid.

Test Plan:
- N_IN=4, SHIFT=4, bias=0, products 16,16,16,16 back-to-back -> out_data=4, out_sat=0, out_valid high the cycle after the 4th accept.
- bias=8, products 0,0,0,0 -> 1 (half rounds up); bias=-8, products 0,0,0,0 -> 0; bias=-9, products 0,0,0,0 -> -1.
- Products 2097151 x4, bias=0 -> sum 8388604, r=524288 -> out_data=32767, out_sat=1. Products -2097152 x4 -> out_data=-32768, out_sat=1.
- Hold out_ready=0 for 5 cycles after out_valid -> out_data/out_valid stable and prod_ready=0 throughout. Raise out_ready -> one handshake, then prod_ready=1 the next cycle. Products presented meanwhile are not consumed.
- Random prod_valid gaps (about 50% duty) over 20 frames with random bias/products -> every output matches the reference model; exactly one output per N_IN accepts.
- Assert ap_rst_n low after 2 of 4 products -> all outputs 0 immediately. After release, a full frame of 16,16,16,16 yields 4 with no residue from the aborted frame.
